// File: rtl/mac8_pkg.sv
// mac8_pkg: shared types and widths for the mac_8 time-domain datapath
package mac8_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_ACC_W = 16;
    localparam int NT_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIGH,
        DONE
    } state_t;

endpackage

// File: rtl/tdc_pw_cnt.sv
// tdc_pw_cnt: edge detector plus saturating pulse-width counter for one DTC pulse
module tdc_pw_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tdc_in,
    input  logic             en_rise,
    input  logic             en_cnt,
    output logic [CNT_W-1:0] cnt,
    output logic             rise,
    output logic             done,
    output logic             sat
);

    logic             tdc_d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // a rising edge restarts the count at 1; high cycles while counting add one, clipped at full scale
    always_comb begin
        rise  = tdc_in & ~tdc_d_q;
        done  = en_cnt & ~tdc_in;
        sat   = en_cnt & tdc_in & (&cnt_q);
        cnt_d = (en_rise && rise) ? CNT_W'(1) :
                (en_cnt && tdc_in && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // previous input sample for edge detection and the running width
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tdc_d_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            tdc_d_q <= tdc_in;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tdc_acc.sv
// tdc_acc: sums the widths of a programmed number of DTC pulses into a saturating MAC result
module tdc_acc
    import mac8_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NT_W-1:0]  n_terms,
    input  logic             tdc_in,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             busy,
    output logic             ovf
);

    state_t           state_q, state_d;
    logic [NT_W-1:0]  rem_q, rem_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] pw_cnt;
    logic             pw_rise, pw_done, pw_sat;

    // start overrides everything, so a pulse edge in the start cycle is never acted on
    tdc_pw_cnt #(.CNT_W(CNT_W)) u_pw (
        .clk     (clk),
        .rst     (rst),
        .tdc_in  (tdc_in),
        .en_rise (state_q == ARMED && !start),
        .en_cnt  (state_q == HIGH && !start),
        .cnt     (pw_cnt),
        .rise    (pw_rise),
        .done    (pw_done),
        .sat     (pw_sat)
    );

    // frame sequencing, remaining-terms countdown and saturating accumulation
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q | pw_sat;
        sum     = {1'b0, acc_q} + (ACC_W+1)'(pw_cnt);
        if (start) begin
            state_d = (n_terms == '0) ? DONE : ARMED;
            rem_d   = n_terms;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ARMED: state_d = pw_rise ? HIGH : ARMED;
                HIGH: if (pw_done) begin
                    acc_d   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                    ovf_d   = ovf_q | sum[ACC_W];
                    count_d = pw_cnt;
                    rem_d   = rem_q - NT_W'(1);
                    state_d = (rem_q == NT_W'(1)) ? DONE : ARMED;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // frame state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_out   = acc_q;
    assign count_out = count_q;
    assign ovf       = ovf_q;
    assign valid     = (state_q == DONE);
    assign busy      = (state_q == ARMED) || (state_q == HIGH);

endmodule

// File: tb/tb_tdc_acc.sv
// tb_tdc_acc: randomized pulse-burst bench against a width-sum reference model
module tb_tdc_acc;
    import mac8_pkg::*;

    localparam int CNT_W = 8;
    localparam int ACC_W = 10;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int AMAX  = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             tdc_in = 1'b0;
    logic [NT_W-1:0]  n_terms = '0;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] count_out;
    logic             valid, busy, ovf;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;
    int exp_acc = 0;
    int exp_ovf = 0;

    tdc_acc #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_terms   (n_terms),
        .tdc_in    (tdc_in),
        .acc_out   (acc_out),
        .count_out (count_out),
        .valid     (valid),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one frame: optional ignored pulse already high at start, then the listed pulses, then tail idle cycles
    task automatic run_frame(input int widths[$], input int pre, input int gap_max, input int tail);
        int seq[$];
        int raw, vidx, n;
        n = widths.size();
        raw = 0;
        exp_ovf = 0;
        repeat (pre) seq.push_back(1);
        if (pre > 0) seq.push_back(0);
        repeat ($urandom_range(0, 2)) seq.push_back(0);
        foreach (widths[i]) begin
            if (i > 0) repeat ($urandom_range(1, gap_max)) seq.push_back(0);
            repeat (widths[i]) seq.push_back(1);
            raw += (widths[i] > CMAX) ? CMAX : widths[i];
            if (widths[i] > CMAX) exp_ovf = 1;
        end
        seq.push_back(0);
        vidx = seq.size() - 1;
        if (raw > AMAX) exp_ovf = 1;
        exp_acc = (raw > AMAX) ? AMAX : raw;
        start = 1'b1;
        n_terms = NT_W'(n);
        tdc_in = (pre > 0);
        tick();
        start = 1'b0;
        if (n == 0) begin
            exp_acc = 0;
            check("zero_valid", valid, 1);
            check("zero_busy", busy, 0);
            check("zero_acc", acc_out, 0);
            check("zero_ovf", ovf, 0);
            check("zero_count_hold", count_out, exp_count);
        end else begin
            check("start_busy", busy, 1);
            check("start_valid", valid, 0);
            foreach (seq[j]) begin
                tdc_in = seq[j][0];
                tick();
                check("valid_timing", valid, (j == vidx) ? 1 : 0);
                check("busy", busy, (j < vidx) ? 1 : 0);
                if (j == vidx) begin
                    exp_count = (widths[n-1] > CMAX) ? CMAX : widths[n-1];
                    check("acc", acc_out, exp_acc);
                    check("count", count_out, exp_count);
                    check("ovf", ovf, exp_ovf);
                end
            end
        end
        repeat (tail) begin
            tdc_in = (n == 0) ? 1'($urandom) : 1'b0;
            tick();
            check("idle_valid", valid, 0);
            check("idle_busy", busy, 0);
            check("idle_acc_hold", acc_out, exp_acc);
            check("idle_ovf_hold", ovf, exp_ovf);
        end
        tdc_in = 1'b0;
    endtask

    initial begin
        int w[$];
        #12;
        check("rst_acc", acc_out, 0);
        check("rst_count", count_out, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b1;
        tick();

        w = {5};
        run_frame(w, 0, 1, 2);
        w = {3, 7, 12};
        run_frame(w, 0, 1, 2);
        w = {};
        run_frame(w, 0, 1, 6);
        w = {250, 250, 250, 250, 250};
        run_frame(w, 0, 2, 1);
        w = {2};
        run_frame(w, 0, 1, 1);
        w = {300};
        run_frame(w, 0, 1, 1);

        start = 1'b1;
        n_terms = NT_W'(2);
        tick();
        start = 1'b0;
        repeat (3) begin tdc_in = 1'b1; tick(); check("abort_busy", busy, 1); end
        tdc_in = 1'b0;
        tick();
        exp_count = 3;
        check("abort_count", count_out, exp_count);
        repeat (2) begin tdc_in = 1'b1; tick(); check("abort_valid", valid, 0); end
        w = {4};
        run_frame(w, 3, 1, 2);

        for (int f = 0; f < 20; f++) begin
            w = {};
            repeat ($urandom_range(1, 5)) w.push_back($urandom_range(1, 20));
            run_frame(w, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 3, $urandom_range(0, 2));
        end

        w = {};
        run_frame(w, 0, 1, 0);
        w = {6, 1};
        run_frame(w, 0, 1, 1);

        start = 1'b1;
        n_terms = NT_W'(2);
        tick();
        start = 1'b0;
        tdc_in = 1'b1;
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_acc", acc_out, 0);
        check("mid_rst_count", count_out, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", ovf, 0);
        tdc_in = 1'b0;
        exp_count = 0;
        tick();
        #2 rst = 1'b1;
        tick();
        w = {9, 2};
        run_frame(w, 0, 2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
